alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Multi-cycle issue and capture controller directly upstream of the ALU. It accepts an encoded opcode and two 32-bit operands with a start/ready handshake. It holds the operands and the 13-bit one-hot ALU control stable for a programmable settle window, then captures the ALU's 64-bit result into a Z-style holding register. It presents that result as lo/hi words with a valid/ready handshake to the register-file/HI-LO write stage.

## Interface
Parameters:
- MULDIV_WAIT, 4: EXEC cycles for MUL/DIV (multicycle combinational paths); legal 1..15.
- BASIC_WAIT, 1: EXEC cycles for all other ops; legal 1..15.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- clear  in  1  reset; synchronous, active-low. Highest priority.
- start  in  1  request; sampled only in IDLE.
- op  in  4  opcode: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 MUL, 5 DIV, 6 SHR, 7 SHRA, 8 SHL, 9 ROR, 10 ROL, 11 NEG, 12 NOT; 13–15 illegal.
- a_in, b_in  in  32  operands; sampled with start.
- alu_c  in  64  ALU result.
- res_ready  in  1  downstream accepts the result.
- alu_a, alu_b  out  32  registered operands driven to the ALU.
- alu_control  out  13  one-hot equal to 1<<op during EXEC; 0 otherwise.
- busy  out  1  high in any state other than IDLE.
- res_valid  out  1  result available.
- res_lo, res_hi  out  32  captured result.
- res_wide  out  1  result targets HI/LO (MUL, DIV).
- illegal_op  out  1  qualifies res_valid for an op value of 13–15.

## Operation
- The controller has three states: IDLE, EXEC, DONE.
- **IDLE, start=1, legal op:**
  - Latch a_in/b_in into alu_a/alu_b.
  - Latch op.
  - Load the counter with WAIT-1.
  - Next state is EXEC.
- **IDLE, start=1, illegal op:**
  - Next state is DONE.
  - illegal_op=1, res_lo=res_hi=0.
  - alu_control is never asserted.
- **EXEC:**
  - alu_control = 1<<op.
  - Operands are held.
  - The counter decrements each cycle.
  - On the cycle the counter reads 0, capture the result per the rules below; next state is DONE.
- **Capture rules:**
  - MUL: lo=alu_c[31:0], hi=alu_c[63:32], res_wide=1.
  - DIV: lo=quotient=alu_c[31:0], hi=remainder=alu_c[63:32], res_wide=1.
  - ADD: lo=alu_c[31:0], hi={31'b0, alu_c[32]} (carry), res_wide=0.
  - All others: lo=alu_c[31:0], hi=0, res_wide=0. Upper bits from widened shifts are discarded.
- **DONE:**
  - res_valid=1; lo/hi/res_wide/illegal_op are held.
  - res_ready=1 returns the controller to IDLE next cycle.
  - Otherwise the controller holds indefinitely.
- **start outside IDLE:** ignored and not queued.
- **Leaving DONE:** res_valid, res_wide and illegal_op clear. res_lo/res_hi keep their last value.
- **Reset:** clear=0 at an edge forces IDLE from any state. All outputs become 0, including alu_a, alu_b, alu_control, res_lo and res_hi. Any in-flight or pending result is dropped.

## Timing
- Cycle 0: start is sampled in IDLE.
- Cycles 1..N: EXEC, where N = MULDIV_WAIT or BASIC_WAIT. Capture occurs at the end of cycle N.
- Cycle N+1: res_valid first high. With res_ready=1, the unit is back in IDLE at N+2.
- Minimum start-to-start spacing: N+2 cycles.
- Illegal op: res_valid high at cycle 1.
- busy rises at cycle 1 and falls on entry to IDLE.
- alu_control is exactly N cycles wide, with no glitch between back-to-back ops.
- clear low on the same edge as start: reset wins and start is ignored.

## Structure
- **Shared package `alu_pkg`:**
  - opcode localparams OP_AND..OP_NOT.
  - ALU_CTRL_W = 13.
  - the state enum {IDLE, EXEC, DONE}.
  - helper function is_wide(op).
- **Sub-module `alu_op_decode`:** combinational. Maps the 4-bit op to the 13-bit one-hot, plus the wide and illegal flags. Reused later by the main control unit.
- The counter, FSM and result register stay in the top level.

## Test plan
- **Reset:** clear low 2 cycles mid-random traffic → all outputs 0 next cycle; busy=0.
- **ADD:** A=0xFFFFFFFF, B=1, BASIC_WAIT=1 → alu_control=0x0004 for cycle 1 only; at cycle 2 res_valid=1, res_lo=0, res_hi=1, res_wide=0.
- **MUL:** A=0x00010000, B=0x00010000, MULDIV_WAIT=4 → alu_control=0x0010 for cycles 1–4; at cycle 5 res_hi=1, res_lo=0, res_wide=1.
- **DIV with backpressure:** 17/5 → res_lo=3, res_hi=2. Hold res_ready=0 for 3 cycles → values held. A start pulse during the hold is ignored. res_ready=1 → IDLE next cycle.
- **SHL / illegal op:**
  - SHL A=0x80000001, B=1 → res_lo=0x00000002, res_hi=0.
  - op=14 → illegal_op=1 and res_valid at cycle 1; alu_control stays 0.
- **Reset mid-EXEC:** clear=0 during cycle 2 of MUL → IDLE and zeros next cycle; res_valid is never asserted for that op.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode map, control width, FSM state type and decode helpers for the ALU front end.
package alu_pkg;

  localparam int unsigned ALU_CTRL_W = 13;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_MUL  = 4'd4;
  localparam logic [3:0] OP_DIV  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_SHRA = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_ROR  = 4'd9;
  localparam logic [3:0] OP_ROL  = 4'd10;
  localparam logic [3:0] OP_NEG  = 4'd11;
  localparam logic [3:0] OP_NOT  = 4'd12;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  // MUL and DIV produce a full 64-bit result destined for HI/LO.
  function automatic logic is_wide(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: one-hot ALU control plus wide/illegal flags.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [3:0]            op,
  output logic [ALU_CTRL_W-1:0] onehot,
  output logic                  wide,
  output logic                  illegal
);

  // Opcodes above OP_NOT have no ALU function and must never raise a control line.
  always_comb begin
    illegal = (op > OP_NOT);
    wide    = is_wide(op);
    onehot  = '0;
    if (!illegal) begin
      onehot = ALU_CTRL_W'(1) << op;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/capture controller in front of the ALU: holds operands and one-hot control for a
// settle window, captures the 64-bit result and hands it downstream via valid/ready.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned MULDIV_WAIT = 4,
  parameter int unsigned BASIC_WAIT  = 1
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  start,
  input  logic [3:0]            op,
  input  logic [31:0]           a_in,
  input  logic [31:0]           b_in,
  input  logic [63:0]           alu_c,
  input  logic                  res_ready,
  output logic [31:0]           alu_a,
  output logic [31:0]           alu_b,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  busy,
  output logic                  res_valid,
  output logic [31:0]           res_lo,
  output logic [31:0]           res_hi,
  output logic                  res_wide,
  output logic                  illegal_op
);

  // Counter load values: the counter reads 0 on the last EXEC cycle.
  localparam logic [3:0] MulDivLoad = 4'(MULDIV_WAIT - 1);
  localparam logic [3:0] BasicLoad  = 4'(BASIC_WAIT - 1);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [3:0]            op_q, op_d;
  logic [31:0]           alu_a_q, alu_a_d;
  logic [31:0]           alu_b_q, alu_b_d;
  logic [ALU_CTRL_W-1:0] ctrl_q, ctrl_d;
  logic                  busy_q, busy_d;
  logic                  valid_q, valid_d;
  logic [31:0]           lo_q, lo_d;
  logic [31:0]           hi_q, hi_d;
  logic                  wide_q, wide_d;
  logic                  illegal_q, illegal_d;

  logic [ALU_CTRL_W-1:0] dec_onehot;
  logic                  dec_wide;
  logic                  dec_illegal;

  alu_op_decode u_dec (
    .op      (op),
    .onehot  (dec_onehot),
    .wide    (dec_wide),
    .illegal (dec_illegal)
  );

  // Next-state logic for FSM, settle counter, operand latches and result register.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    ctrl_d    = ctrl_q;
    busy_d    = busy_q;
    valid_d   = valid_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    wide_d    = wide_q;
    illegal_d = illegal_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (dec_illegal) begin
            // Skip EXEC entirely; report a zero result flagged illegal.
            state_d   = DONE;
            valid_d   = 1'b1;
            lo_d      = '0;
            hi_d      = '0;
            wide_d    = 1'b0;
            illegal_d = 1'b1;
          end else begin
            state_d = EXEC;
            alu_a_d = a_in;
            alu_b_d = b_in;
            op_d    = op;
            ctrl_d  = dec_onehot;
            cnt_d   = dec_wide ? MulDivLoad : BasicLoad;
          end
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d   = DONE;
          ctrl_d    = '0;
          valid_d   = 1'b1;
          illegal_d = 1'b0;
          lo_d      = alu_c[31:0];
          wide_d    = is_wide(op_q);
          if (is_wide(op_q)) begin
            hi_d = alu_c[63:32];
          end else if (op_q == OP_ADD) begin
            hi_d = {31'b0, alu_c[32]};
          end else begin
            hi_d = '0;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          valid_d   = 1'b0;
          wide_d    = 1'b0;
          illegal_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
        ctrl_d  = '0;
      end
    endcase
  end

  // State registers with synchronous active-low clear; clear drops any pending result.
  always_ff @(posedge clk) begin
    if (!clear) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      ctrl_q    <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      lo_q      <= '0;
      hi_q      <= '0;
      wide_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      ctrl_q    <= ctrl_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      wide_q    <= wide_d;
      illegal_q <= illegal_d;
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_control = ctrl_q;
  assign busy        = busy_q;
  assign res_valid   = valid_q;
  assign res_lo      = lo_q;
  assign res_hi      = hi_q;
  assign res_wide    = wide_q;
  assign illegal_op  = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU on alu_c, scoreboard of expected results.
module tb_alu_issue_ctrl;

  localparam int unsigned MulDivN = 4;
  localparam int unsigned BasicN  = 1;

  logic        clk = 1'b0;
  logic        clear;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a_in, b_in;
  logic [63:0] alu_c;
  logic        res_ready;
  logic [31:0] alu_a, alu_b;
  logic [12:0] alu_control;
  logic        busy, res_valid, res_wide, illegal_op;
  logic [31:0] res_lo, res_hi;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        wide;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;

  alu_issue_ctrl #(
    .MULDIV_WAIT (MulDivN),
    .BASIC_WAIT  (BasicN)
  ) dut (
    .clk         (clk),
    .clear       (clear),
    .start       (start),
    .op          (op),
    .a_in        (a_in),
    .b_in        (b_in),
    .alu_c       (alu_c),
    .res_ready   (res_ready),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_control (alu_control),
    .busy        (busy),
    .res_valid   (res_valid),
    .res_lo      (res_lo),
    .res_hi      (res_hi),
    .res_wide    (res_wide),
    .illegal_op  (illegal_op)
  );

  always #5 clk = ~clk;

  // Behavioural ALU producing widened 64-bit results, keyed by the one-hot control.
  always_comb begin
    logic [4:0]  s;
    logic [63:0] dbl;
    s     = alu_b[4:0];
    dbl   = {alu_a, alu_a};
    alu_c = 64'h0;
    case (alu_control)
      13'h0001: alu_c = {32'h0, alu_a & alu_b};
      13'h0002: alu_c = {32'h0, alu_a | alu_b};
      13'h0004: alu_c = {32'h0, alu_a} + {32'h0, alu_b};
      13'h0008: alu_c = {32'h0, alu_a} - {32'h0, alu_b};
      13'h0010: alu_c = {32'h0, alu_a} * {32'h0, alu_b};
      13'h0020: alu_c = (alu_b == 0) ? {alu_a, 32'hFFFF_FFFF}
                                     : {alu_a % alu_b, alu_a / alu_b};
      13'h0040: alu_c = {32'h0, alu_a >> s};
      13'h0080: alu_c = {{32{alu_a[31]}}, 32'($signed(alu_a) >>> s)};
      13'h0100: alu_c = {32'h0, alu_a} << s;
      13'h0200: alu_c = {32'h0, dbl[31:0] >> 0} & 64'h0 | {32'h0, 32'(dbl >> s)};
      13'h0400: alu_c = {32'h0, 32'({alu_a, alu_a} >> (6'd32 - {1'b0, s}))};
      13'h0800: alu_c = {32'hFFFF_FFFF, 32'(0 - alu_a)};
      13'h1000: alu_c = {32'hFFFF_FFFF, ~alu_a};
      default:  alu_c = 64'h0;
    endcase
  end

  // Reference result for one operation, computed straight from op/operands.
  function automatic exp_t ref_res(input logic [3:0] o, input logic [31:0] a,
                                   input logic [31:0] b);
    exp_t        e;
    logic [32:0] sum;
    logic [63:0] prod;
    int          s;
    s      = int'(b[4:0]);
    e      = '0;
    sum    = {1'b0, a} + {1'b0, b};
    prod   = 64'(a) * 64'(b);
    case (o)
      4'd0:  e.lo = a & b;
      4'd1:  e.lo = a | b;
      4'd2:  begin e.lo = sum[31:0]; e.hi = {31'h0, sum[32]}; end
      4'd3:  e.lo = a - b;
      4'd4:  begin e.lo = prod[31:0]; e.hi = prod[63:32]; e.wide = 1'b1; end
      4'd5:  begin
        e.wide = 1'b1;
        e.lo   = (b == 0) ? 32'hFFFF_FFFF : a / b;
        e.hi   = (b == 0) ? a : a % b;
      end
      4'd6:  e.lo = a >> s;
      4'd7:  e.lo = 32'($signed(a) >>> s);
      4'd8:  e.lo = a << s;
      4'd9:  e.lo = (s == 0) ? a : ((a >> s) | (a << (32 - s)));
      4'd10: e.lo = (s == 0) ? a : ((a << s) | (a >> (32 - s)));
      4'd11: e.lo = ~a + 32'd1;
      4'd12: e.lo = ~a;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".alu_a"}, 64'(alu_a), 64'h0);
    chk({tag, ".alu_b"}, 64'(alu_b), 64'h0);
    chk({tag, ".alu_control"}, 64'(alu_control), 64'h0);
    chk({tag, ".busy"}, 64'(busy), 64'h0);
    chk({tag, ".res_valid"}, 64'(res_valid), 64'h0);
    chk({tag, ".res_lo"}, 64'(res_lo), 64'h0);
    chk({tag, ".res_hi"}, 64'(res_hi), 64'h0);
    chk({tag, ".res_wide"}, 64'(res_wide), 64'h0);
    chk({tag, ".illegal_op"}, 64'(illegal_op), 64'h0);
  endtask

  task automatic chk_result(input string tag);
    chk({tag, ".res_lo"}, 64'(res_lo), 64'(cur.lo));
    chk({tag, ".res_hi"}, 64'(res_hi), 64'(cur.hi));
    chk({tag, ".res_wide"}, 64'(res_wide), 64'(cur.wide));
    chk({tag, ".illegal_op"}, 64'(illegal_op), 64'(cur.ill));
  endtask

  // Issue one op, check the EXEC window, then pop/compare once res_valid appears.
  // hold: cycles of res_ready=0 in DONE; poke: pulse start during the hold.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int hold, input bit poke);
    int   n;
    int   waited;
    logic [12:0] exp_ctrl;
    exp_ctrl = (o > 4'd12) ? 13'h0 : (13'h1 << o);
    n        = (o > 4'd12) ? 0 : ((o == 4'd4 || o == 4'd5) ? int'(MulDivN) : int'(BasicN));
    start = 1'b1;
    op    = o;
    a_in  = a;
    b_in  = b;
    sb_q.push_back(ref_res(o, a, b));
    step();
    start = 1'b0;
    a_in  = $urandom;
    b_in  = $urandom;
    for (int i = 0; i < n; i++) begin
      chk({tag, ".exec_ctrl"}, 64'(alu_control), 64'(exp_ctrl));
      chk({tag, ".exec_busy"}, 64'(busy), 64'h1);
      chk({tag, ".exec_valid"}, 64'(res_valid), 64'h0);
      chk({tag, ".exec_a"}, 64'(alu_a), 64'(a));
      step();
    end
    waited = 0;
    while (!res_valid && waited < 20) begin
      step();
      waited++;
    end
    chk({tag, ".latency_extra"}, 64'(waited), 64'h0);
    if (res_valid && sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      chk({tag, ".done_ctrl"}, 64'(alu_control), 64'h0);
      chk_result(tag);
      for (int h = 0; h < hold; h++) begin
        res_ready = 1'b0;
        if (poke && h == 0) begin
          start = 1'b1;
          op    = 4'd2;
        end
        step();
        start = 1'b0;
        chk({tag, ".hold_valid"}, 64'(res_valid), 64'h1);
        chk_result({tag, ".hold"});
      end
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      chk({tag, ".idle_busy"}, 64'(busy), 64'h0);
      chk({tag, ".idle_valid"}, 64'(res_valid), 64'h0);
      chk({tag, ".idle_wide"}, 64'(res_wide), 64'h0);
      chk({tag, ".idle_illegal"}, 64'(illegal_op), 64'h0);
      chk({tag, ".idle_lo_kept"}, 64'(res_lo), 64'(cur.lo));
    end else begin
      chk({tag, ".res_valid_timeout"}, 64'(res_valid), 64'h1);
      sb_q.delete();
    end
  endtask

  initial begin
    clear     = 1'b0;
    start     = 1'b0;
    op        = 4'd0;
    a_in      = 32'h0;
    b_in      = 32'h0;
    res_ready = 1'b0;
    step();
    step();
    chk_zero("reset");
    clear = 1'b1;
    step();

    // Directed cases.
    run_op("add_carry", 4'd2, 32'hFFFF_FFFF, 32'h1, 0, 1'b0);
    chk("add_carry.hi", 64'(res_hi), 64'h1);
    run_op("mul", 4'd4, 32'h0001_0000, 32'h0001_0000, 0, 1'b0);
    chk("mul.hi", 64'(res_hi), 64'h1);
    run_op("div_bp", 4'd5, 32'd17, 32'd5, 3, 1'b1);
    chk("div_bp.lo", 64'(res_lo), 64'd3);
    chk("div_bp.hi", 64'(res_hi), 64'd2);
    step();
    chk("div_bp.start_not_queued", 64'(busy), 64'h0);
    run_op("shl", 4'd8, 32'h8000_0001, 32'h1, 0, 1'b0);
    chk("shl.lo", 64'(res_lo), 64'h2);
    run_op("illegal14", 4'd14, 32'h1234_5678, 32'h9, 1, 1'b0);
    run_op("sub_borrow", 4'd3, 32'h0, 32'h1, 0, 1'b0);
    run_op("sra", 4'd7, 32'h8000_0000, 32'd4, 0, 1'b0);
    run_op("ror", 4'd9, 32'h0000_0001, 32'd1, 0, 1'b0);

    // Random traffic, then clear held low for 2 cycles in the middle of an op.
    for (int k = 0; k < 10; k++) begin
      logic [3:0]  ro;
      logic [31:0] rb;
      ro = 4'($urandom_range(0, 15));
      rb = $urandom;
      if (ro == 4'd5 && rb == 0) rb = 32'd7;
      run_op("rand", ro, $urandom, rb, int'($urandom_range(0, 2)), 1'b0);
    end
    start = 1'b1;
    op    = 4'd4;
    a_in  = $urandom;
    b_in  = $urandom;
    step();
    start = 1'b0;
    clear = 1'b0;
    step();
    step();
    chk_zero("mid_reset");
    clear = 1'b1;

    // Reset during cycle 2 of a MUL: result must never appear.
    start = 1'b1;
    op    = 4'd4;
    a_in  = 32'h3;
    b_in  = 32'h5;
    step();
    start = 1'b0;
    step();
    clear = 1'b0;
    step();
    clear = 1'b1;
    chk_zero("mul_abort");
    for (int i = 0; i < 8; i++) begin
      chk("mul_abort.no_valid", 64'(res_valid), 64'h0);
      step();
    end

    // Clear and start on the same edge: reset wins.
    clear = 1'b0;
    start = 1'b1;
    op    = 4'd0;
    step();
    clear = 1'b1;
    start = 1'b0;
    chk("clear_vs_start.busy", 64'(busy), 64'h0);
    step();
    chk("clear_vs_start.busy_after", 64'(busy), 64'h0);

    // Controller must still work after the resets.
    run_op("post_reset_and", 4'd0, 32'hF0F0_FFFF, 32'h0FF0_00FF, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard timeout so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
